// File: rtl/comparison.sv
// comparison: registers an ASCII byte and classifies it as decimal digit or whitespace.
// Latency: one clock from the sampling edge to data_out/is_number/is_white.
// Backpressure: none. A byte is accepted on every edge with enable=1, and outputs hold while enable=0.
//
// Ports:
//   clk        rising-edge clock for all state
//   enable     sample and classify data_in on this edge
//   data_in    input character byte
//   data_out   registered copy of the last sampled byte
//   is_number  registered flag: data_out is '0'..'9'
//   is_white   registered flag: data_out is SP, HT, LF, VT, FF or CR
//   rst_n      synchronous active-low reset; takes priority over enable
module comparison (
  input  logic       clk,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       is_number,
  output logic       is_white,
  input  logic       rst_n
);

  logic next_number;
  logic next_white;

  // The classification is decoded from data_in ahead of the register.
  // This keeps the flags in step with data_out, and every output stays a plain flop.
  always_comb begin
    next_number = (data_in >= 8'h30) && (data_in <= 8'h39);
    next_white  = 1'b0;
    case (data_in)
      8'h20, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D: next_white = 1'b1;
      default:                                  next_white = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= 8'h00;
      is_number <= 1'b0;
      is_white  <= 1'b0;
    end else if (enable) begin
      data_out  <= data_in;
      is_number <= next_number;
      is_white  <= next_white;
    end
  end

endmodule

// File: tb/tb_comparison.sv
// tb_comparison: directed-vector scoreboard bench for comparison.
// Latency: expectations are pushed at the driving falling edge and checked 1 time unit after the next rising edge.
// Backpressure: none. The DUT presents a result on every edge, so the monitor pops whenever the queue is non-empty.
module tb_comparison;

  logic       clk;
  logic       enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       is_number;
  logic       is_white;
  logic       rst_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] dat;
    logic       num;
    logic       wht;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  comparison dut (
    .clk       (clk),
    .enable    (enable),
    .data_in   (data_in),
    .data_out  (data_out),
    .is_number (is_number),
    .is_white  (is_white),
    .rst_n     (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference classification for the sweep, written from the ASCII code tables.
  function automatic logic ref_num(input logic [7:0] c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  function automatic logic ref_wht(input logic [7:0] c);
    return (c == 8'd32) || ((c >= 8'd9) && (c <= 8'd13));
  endfunction

  // Drive one edge's inputs at the falling edge and queue the result expected after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d,
                      input logic [7:0] ed, input logic en_num, input logic en_wht,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    enable  = e;
    data_in = d;
    x.dat  = ed;
    x.num  = en_num;
    x.wht  = en_wht;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (data_out !== x.dat) begin
        failures++;
        $display("FAIL %s data_out actual=%h required=%h", x.name, data_out, x.dat);
      end
      checks++;
      if (is_number !== x.num) begin
        failures++;
        $display("FAIL %s is_number actual=%b required=%b", x.name, is_number, x.num);
      end
      checks++;
      if (is_white !== x.wht) begin
        failures++;
        $display("FAIL %s is_white actual=%b required=%b", x.name, is_white, x.wht);
      end
      checks++;
      if (is_number === 1'b1 && is_white === 1'b1) begin
        failures++;
        $display("FAIL %s exclusive actual=both_set required=not_both", x.name);
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         wait_cycles;

    rst_n   = 1'b0;
    enable  = 1'b1;
    data_in = 8'h35;

    // Reset holds outputs at zero even with a digit presented and enable high.
    step(1'b0, 1'b1, 8'h35, 8'h00, 1'b0, 1'b0, "reset0");
    step(1'b0, 1'b1, 8'h35, 8'h00, 1'b0, 1'b0, "reset1");

    // Stream "p2 h\t-09".
    step(1'b1, 1'b1, 8'h70, 8'h70, 1'b0, 1'b0, "str_p");
    step(1'b1, 1'b1, 8'h32, 8'h32, 1'b1, 1'b0, "str_2");
    step(1'b1, 1'b1, 8'h20, 8'h20, 1'b0, 1'b1, "str_sp");
    step(1'b1, 1'b1, 8'h68, 8'h68, 1'b0, 1'b0, "str_h");
    step(1'b1, 1'b1, 8'h09, 8'h09, 1'b0, 1'b1, "str_tab");
    step(1'b1, 1'b1, 8'h2D, 8'h2D, 1'b0, 1'b0, "str_dash");
    step(1'b1, 1'b1, 8'h30, 8'h30, 1'b1, 1'b0, "str_0");
    step(1'b1, 1'b1, 8'h39, 8'h39, 1'b1, 1'b0, "str_9");

    // Codes just outside the digit and whitespace ranges, plus high, NUL and the two inner whitespace codes.
    step(1'b1, 1'b1, 8'h2F, 8'h2F, 1'b0, 1'b0, "bnd_2f");
    step(1'b1, 1'b1, 8'h3A, 8'h3A, 1'b0, 1'b0, "bnd_3a");
    step(1'b1, 1'b1, 8'h08, 8'h08, 1'b0, 1'b0, "bnd_08");
    step(1'b1, 1'b1, 8'h0E, 8'h0E, 1'b0, 1'b0, "bnd_0e");
    step(1'b1, 1'b1, 8'h1F, 8'h1F, 1'b0, 1'b0, "bnd_1f");
    step(1'b1, 1'b1, 8'h21, 8'h21, 1'b0, 1'b0, "bnd_21");
    step(1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, "bnd_80");
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, "bnd_ff");
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "bnd_00");
    step(1'b1, 1'b1, 8'h0A, 8'h0A, 1'b0, 1'b1, "bnd_0a");
    step(1'b1, 1'b1, 8'h0D, 8'h0D, 1'b0, 1'b1, "bnd_0d");

    // Hold: with enable low, the outputs keep the registered '7' while a space sits on data_in.
    step(1'b1, 1'b1, 8'h37, 8'h37, 1'b1, 1'b0, "hold_load");
    step(1'b1, 1'b0, 8'h20, 8'h37, 1'b1, 1'b0, "hold_1");
    step(1'b1, 1'b0, 8'h20, 8'h37, 1'b1, 1'b0, "hold_2");
    step(1'b1, 1'b0, 8'h20, 8'h37, 1'b1, 1'b0, "hold_3");
    step(1'b1, 1'b1, 8'h20, 8'h20, 1'b0, 1'b1, "hold_resume");

    // Mid-stream reset discards the presented byte; the next edge loads normally.
    step(1'b0, 1'b1, 8'h34, 8'h00, 1'b0, 1'b0, "mid_rst");
    step(1'b1, 1'b1, 8'h20, 8'h20, 1'b0, 1'b1, "mid_after");

    // Sweep all 256 codes back to back.
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      step(1'b1, 1'b1, b, b, ref_num(b), ref_wht(b), $sformatf("sweep_%02h", b));
    end

    @(negedge clk);
    enable = 1'b0;

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
